// File: rtl/msg_pkg.sv
// Shared types and helpers for the scrolling message buffer.
// Holds the scroll FSM states and the power-up character pattern.
package msg_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default glyph at index i: i modulo 2^w.
  function automatic int def_char(input int i, input int w);
    if (w >= 31) return i;
    return i % (1 << w);
  endfunction

endpackage

// File: rtl/msg_step_div.sv
// Auto-scroll divider: counts 0..STEP_DIV-1 while enabled.
// tc marks the terminal count; the counter returns to 0 there.
module msg_step_div #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int DW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);

  logic [DW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/message_buffer.sv
// Scrolling message buffer with a registered display window.
// Define MSG_BUF_DIR_EN to add a dir input for reverse scrolling.
module message_buffer
  import msg_pkg::*;
#(
  parameter int CHAR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int WIN      = 4,
  parameter int STEP_DIV = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
`ifdef MSG_BUF_DIR_EN
  input  logic                  dir,
`endif
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CHAR_W-1:0]     wr_data,
  output logic [WIN*CHAR_W-1:0] window,
  output logic [AW-1:0]         offset,
  output logic                  wrap
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [CHAR_W-1:0] mem [DEPTH];

  state_t state;
  state_t state_nx;

  logic tc;
  logic clear;
  logic adv;
  logic back;
  logic wr_ok;

  logic [AW-1:0] off_nx;
  logic          wrap_nx;

  logic [WIN*CHAR_W-1:0] win_nx;

`ifdef MSG_BUF_DIR_EN
  assign back = dir;
`else
  assign back = 1'b0;
`endif

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);

  always_comb begin
    state_nx = state;
    adv = 1'b0;
    unique case (state)
      HOLD: begin
        adv = step;
        if (run) state_nx = RUN;
      end
      RUN: begin
        adv = tc;
        if (!run) state_nx = HOLD;
      end
      default: state_nx = HOLD;
    endcase
  end

  // Every mode change restarts the divider from zero.
  assign clear = (state != state_nx);

  msg_step_div #(
    .STEP_DIV (STEP_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (state == RUN),
    .tc    (tc)
  );

  always_comb begin
    off_nx = offset;
    wrap_nx = 1'b0;
    if (adv) begin
      if (back) begin
        if (offset == '0) begin
          off_nx = LAST;
          wrap_nx = 1'b1;
        end else begin
          off_nx = offset - AW'(1);
        end
      end else begin
        if (offset == LAST) begin
          off_nx = '0;
          wrap_nx = 1'b1;
        end else begin
          off_nx = offset + AW'(1);
        end
      end
    end
  end

  // Window taps wrap past the last character back to index 0.
  for (genvar k = 0; k < WIN; k++) begin : g_slot
    logic [AW:0] raw;
    logic [AW:0] idx;
    assign raw = {1'b0, offset} + (AW+1)'(k);
    assign idx = (raw >= DEPTH_L) ? raw - DEPTH_L : raw;
    assign win_nx[k*CHAR_W +: CHAR_W] = mem[idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CHAR_W'(def_char(i, CHAR_W));
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= HOLD;
      offset <= '0;
      wrap   <= 1'b0;
      for (int k = 0; k < WIN; k++) begin
        window[k*CHAR_W +: CHAR_W] <=
          CHAR_W'(def_char(k, CHAR_W));
      end
    end else begin
      state  <= state_nx;
      offset <= off_nx;
      wrap   <= wrap_nx;
      window <= win_nx;
    end
  end

endmodule

// File: tb/tb_message_buffer.sv
// Self-checking bench for message_buffer (16-deep and 12-deep builds).
// Randomized traffic is compared against a behavioural model.
module tb_message_buffer;

  localparam int CW = 4;
  localparam int D  = 16;
  localparam int W  = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic [15:0] window;
  logic [3:0]  offset;
  logic        wrap;

  logic        reset12 = 1'b1;
  logic        step12 = 1'b0;
  logic        wr_en12 = 1'b0;
  logic [3:0]  wr_addr12 = '0;
  logic [3:0]  wr_data12 = '0;
  logic [15:0] window12;
  logic [3:0]  offset12;
  logic        wrap12;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  message_buffer #(
    .CHAR_W(CW), .DEPTH(D), .WIN(W), .STEP_DIV(SD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .step    (step),
`ifdef MSG_BUF_DIR_EN
    .dir     (dir),
`endif
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .window  (window),
    .offset  (offset),
    .wrap    (wrap)
  );

  message_buffer #(
    .CHAR_W(CW), .DEPTH(12), .WIN(W), .STEP_DIV(SD)
  ) dut12 (
    .clk     (clk),
    .reset   (reset12),
    .run     (1'b0),
    .step    (step12),
`ifdef MSG_BUF_DIR_EN
    .dir     (1'b0),
`endif
    .wr_en   (wr_en12),
    .wr_addr (wr_addr12),
    .wr_data (wr_data12),
    .window  (window12),
    .offset  (offset12),
    .wrap    (wrap12)
  );

  // Behavioural model of the 16-deep instance.
  int          m_mem [D];
  int          m_off = 0;
  int          m_div = 0;
  bit          m_run = 1'b0;
  bit          m_wrap = 1'b0;
  logic [15:0] m_win = '0;

  function automatic logic [15:0] view();
    logic [15:0] v;
    for (int k = 0; k < W; k++)
      v[k*CW +: CW] = 4'(m_mem[(m_off + k) % D]);
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] w;
    bit adv;
    if (reset) begin
      for (int i = 0; i < D; i++) m_mem[i] = i % 16;
      m_off = 0;
      m_div = 0;
      m_run = 1'b0;
      m_wrap = 1'b0;
      m_win = view();
    end else begin
      w = view();
      adv = m_run ? (m_div == SD - 1) : step;
      if (m_run != run) m_div = 0;
      else if (m_run) m_div = (m_div + 1) % SD;
      if (wr_en && int'(wr_addr) < D)
        m_mem[wr_addr] = int'(wr_data);
      m_wrap = 1'b0;
      if (adv) begin
        if (dir) begin
          m_wrap = (m_off == 0);
          m_off = (m_off + D - 1) % D;
        end else begin
          m_wrap = (m_off == D - 1);
          m_off = (m_off + 1) % D;
        end
      end
      m_run = run;
      m_win = w;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    run = 1'b0; step = 1'b0; wr_en = 1'b0;
    reset = 1'b1;
    tick(1);
    checks++;
    if (window !== 16'h3210) begin
      fails++;
      $display("FAIL reset_window got %h want %h",
               window, 16'h3210);
    end
    checks++;
    if (offset !== 4'd0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_offs got %0d/%b want 0/0",
               offset, wrap);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if (window !== 16'h3210) begin
      fails++;
      $display("FAIL reset_hold got %h want %h",
               window, 16'h3210);
    end
  endtask

  task automatic test_run_scroll();
    reset = 1'b1; tick(1); reset = 1'b0;
    run = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick(1);
      checks++;
      if (offset !== 4'(m_off) || wrap !== m_wrap) begin
        fails++;
        $display("FAIL scroll_c%0d got %0d/%b want %0d/%b",
                 c, offset, wrap, m_off, m_wrap);
      end
    end
    checks++;
    if (offset !== 4'd4) begin
      fails++;
      $display("FAIL scroll_final got %0d want 4", offset);
    end
    tick(1);
    checks++;
    if (window !== 16'h7654) begin
      fails++;
      $display("FAIL scroll_window got %h want %h",
               window, 16'h7654);
    end
    run = 1'b0;
    tick(1);
  endtask

  task automatic test_step_wrap();
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step = 1'b1; tick(1);
      step = 1'b0; tick(1);
      checks++;
      if (window !== m_win || offset !== 4'(m_off)) begin
        fails++;
        $display("FAIL step_%0d got %h/%0d want %h/%0d",
                 i, window, offset, m_win, m_off);
      end
    end
    checks++;
    if (offset !== 4'd14 || window !== 16'h10FE) begin
      fails++;
      $display("FAIL step_14 got %0d/%h want 14/10fe",
               offset, window);
    end
    step = 1'b1; tick(1); step = 1'b0;
    checks++;
    if (offset !== 4'd15 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL step_15 got %0d/%b want 15/0",
               offset, wrap);
    end
    tick(1);
    checks++;
    if (window !== 16'h210F) begin
      fails++;
      $display("FAIL step_15_win got %h want 210f", window);
    end
    step = 1'b1; tick(1); step = 1'b0;
    checks++;
    if (offset !== 4'd0 || wrap !== 1'b1) begin
      fails++;
      $display("FAIL step_wrap got %0d/%b want 0/1",
               offset, wrap);
    end
    tick(1);
    checks++;
    if (wrap !== 1'b0) begin
      fails++;
      $display("FAIL wrap_pulse got %b want 0", wrap);
    end
  endtask

  task automatic test_write();
    reset = 1'b1; tick(1); reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'hA;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    checks++;
    if (window !== 16'h32A0) begin
      fails++;
      $display("FAIL write_win got %h want 32a0", window);
    end
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'h5;
    step = 1'b1;
    tick(1);
    wr_en = 1'b0; step = 1'b0;
    checks++;
    if (offset !== 4'd1) begin
      fails++;
      $display("FAIL wr_adv_off got %0d want 1", offset);
    end
    tick(1);
    checks++;
    if (window !== 16'h4325) begin
      fails++;
      $display("FAIL wr_adv_win got %h want 4325", window);
    end
  endtask

  task automatic test_oob12();
    reset12 = 1'b1; tick(1); reset12 = 1'b0;
    wr_en12 = 1'b1; wr_addr12 = 4'd13; wr_data12 = 4'h5;
    tick(1);
    wr_en12 = 1'b0;
    tick(2);
    checks++;
    if (window12 !== 16'h3210 || offset12 !== 4'd0) begin
      fails++;
      $display("FAIL oob_write got %h/%0d want 3210/0",
               window12, offset12);
    end
    for (int i = 0; i < 11; i++) begin
      step12 = 1'b1; tick(1); step12 = 1'b0;
    end
    tick(1);
    checks++;
    if (offset12 !== 4'd11 || window12 !== 16'h210B) begin
      fails++;
      $display("FAIL d12_last got %0d/%h want 11/210b",
               offset12, window12);
    end
    step12 = 1'b1; tick(1); step12 = 1'b0;
    checks++;
    if (offset12 !== 4'd0 || wrap12 !== 1'b1) begin
      fails++;
      $display("FAIL d12_wrap got %0d/%b want 0/1",
               offset12, wrap12);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1; tick(1); reset = 1'b0;
    run = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    checks++;
    if (window !== 16'h3210 || offset !== 4'd0 ||
        wrap !== 1'b0) begin
      fails++;
      $display("FAIL midrun_rst got %h/%0d/%b want 3210/0/0",
               window, offset, wrap);
    end
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      checks++;
      if (offset !== ((c == 5) ? 4'd1 : 4'd0)) begin
        fails++;
        $display("FAIL midrun_c%0d got %0d want %0d",
                 c, offset, (c == 5) ? 1 : 0);
      end
    end
    run = 1'b0;
    tick(1);
  endtask

`ifdef MSG_BUF_DIR_EN
  task automatic test_dir();
    reset = 1'b1; tick(1); reset = 1'b0;
    dir = 1'b1; step = 1'b1;
    tick(1);
    step = 1'b0;
    checks++;
    if (offset !== 4'd15 || wrap !== 1'b1) begin
      fails++;
      $display("FAIL dir_back got %0d/%b want 15/1",
               offset, wrap);
    end
    tick(1);
    checks++;
    if (window !== 16'h210F) begin
      fails++;
      $display("FAIL dir_win got %h want 210f", window);
    end
    dir = 1'b0;
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; tick(1); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) run = ~run;
      step = ($urandom_range(0, 2) == 0);
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      reset = ($urandom_range(0, 79) == 0);
`ifdef MSG_BUF_DIR_EN
      dir = $urandom_range(0, 1) == 1;
`endif
      tick(1);
      checks++;
      if (window !== m_win || offset !== 4'(m_off) ||
          wrap !== m_wrap) begin
        fails++;
        $display("FAIL rand_%0d got %h/%0d/%b want %h/%0d/%b",
                 c, window, offset, wrap,
                 m_win, m_off, m_wrap);
      end
    end
    reset = 1'b0; run = 1'b0; step = 1'b0;
    wr_en = 1'b0; dir = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(2);
    test_reset();
    test_run_scroll();
    test_step_wrap();
    test_write();
    test_oob12();
    test_reset_mid_run();
`ifdef MSG_BUF_DIR_EN
    test_dir();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
